bcd_7seg_scan: RTL and testbench

- Downstream consumer of the 8-bit binary-to-BCD converter.
- Takes the ones/tens/hundreds BCD digits and drives a 3-digit time-multiplexed 7-segment display.
- Snapshots the digits once per scan frame, so a display frame never shows digits from two different conversions.
- Applies per-slot ghost blanking and configurable output polarity.

---
 rtl/bcd_7seg_scan.sv | 136 +++++++++++++
 tb/tb_bcd_7seg_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
// Three-digit multiplexed 7-segment driver fed by a binary-to-BCD converter.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module bcd_7seg_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYC      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]    snap_o_reg, snap_t_reg, snap_h_reg;
    logic [6:0]    seg_reg;
    logic [2:0]    an_reg;
    logic          frame_tick_reg;

    logic          slot_end;
    logic          in_blank;
    logic [3:0]    cur_digit;
    logic [2:0]    show;
    logic [2:0]    an_next;
    state_t        state_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign slot_end = (cnt_reg == CW'(SCAN_DIV - 1));

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt_reg < CW'(BLANK_CYC));
        end
    endgenerate

    // Leading-zero suppression works on the snapshot, so it is frame-consistent.
`ifdef LEADING_ZERO_BLANK_EN
    assign show[0] = 1'b1;
    assign show[1] = (snap_h_reg != 4'd0) || (snap_t_reg != 4'd0);
    assign show[2] = (snap_h_reg != 4'd0);
`else
    assign show = 3'b111;
`endif

    always_comb begin
        cur_digit  = snap_o_reg;
        state_next = DIG0;
        case (state_reg)
            DIG0: begin
                cur_digit  = snap_o_reg;
                state_next = DIG1;
            end
            DIG1: begin
                cur_digit  = snap_t_reg;
                state_next = DIG2;
            end
            DIG2: begin
                cur_digit  = snap_h_reg;
                state_next = DIG0;
            end
            default: begin
                cur_digit  = snap_o_reg;
                state_next = DIG0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_an
            assign an_next[gi] = (state_reg == state_t'(gi)) && !in_blank && show[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= DIG0;
            cnt_reg        <= '0;
            snap_o_reg     <= '0;
            snap_t_reg     <= '0;
            snap_h_reg     <= '0;
            seg_reg        <= '0;
            an_reg         <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            seg_reg        <= decode(cur_digit);
            an_reg         <= an_next;
            frame_tick_reg <= slot_end && (state_reg == DIG2);
            if (slot_end) begin
                cnt_reg   <= '0;
                state_reg <= state_next;
                if (state_reg == DIG2) begin
                    snap_o_reg <= ones;
                    snap_t_reg <= tens;
                    snap_h_reg <= hundreds;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign seg        = seg_reg ^ {7{SEG_ACTIVE_LOW}};
    assign an         = an_reg ^ {3{AN_ACTIVE_LOW}};
    assign frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan: one active-high instance (BLANK_CYC=1) and
// one active-low instance (BLANK_CYC=0) driven by the same digits and reset.
module tb_bcd_7seg_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0;
    logic [6:0] seg, seg2;
    logic [2:0] an, an2;
    logic       frame_tick, frame_tick2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    bcd_7seg_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .ones(ones), .tens(tens), .hundreds(hundreds),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    bcd_7seg_scan #(.SCAN_DIV(4), .BLANK_CYC(0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .ones(ones), .tens(tens), .hundreds(hundreds),
        .seg(seg2), .an(an2), .frame_tick(frame_tick2)
    );

    typedef struct {
        logic [3:0] o, t, h;
        logic [6:0] s0, s1, s2;   // expected active-high segments per slot
        logic [2:0] show_all;     // digits shown without leading-zero blanking
        logic [2:0] show_lzb;     // digits shown with leading-zero blanking
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [2:0] pick_show(input vec_t v);
`ifdef LEADING_ZERO_BLANK_EN
        return v.show_lzb;
`else
        return v.show_all;
`endif
    endfunction

    // Observe one cycle k (0..11) of a frame that starts right after a boundary.
    task automatic check_cycle(input int k, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [2:0] show);
        int         slot = k / 4;
        int         c    = k % 4;
        logic [6:0] es;
        logic [2:0] onehot;
        logic [2:0] ea, ea2;
        @(posedge clk);
        @(negedge clk);
        es     = (slot == 0) ? s0 : (slot == 1) ? s1 : s2;
        onehot = 3'b001 << slot;
        ea     = (show[slot] && c >= 1) ? onehot : 3'b000;
        ea2    = show[slot] ? ~onehot : 3'b111;
        check($sformatf("seg k=%0d", k), {1'b0, seg}, {1'b0, es});
        check($sformatf("an k=%0d", k), {5'b0, an}, {5'b0, ea});
        check($sformatf("tick k=%0d", k), {7'b0, frame_tick}, {7'b0, (k == 11)});
        check($sformatf("seg_lo k=%0d", k), {1'b0, seg2}, {1'b0, ~es});
        check($sformatf("an_lo k=%0d", k), {5'b0, an2}, {5'b0, ea2});
    endtask

    task automatic check_frame(input vec_t v);
        for (int k = 0; k < 12; k++) check_cycle(k, v.s0, v.s1, v.s2, pick_show(v));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " seg"}, {1'b0, seg}, 8'h00);
        check({tag, " an"}, {5'b0, an}, 8'h00);
        check({tag, " tick"}, {7'b0, frame_tick}, 8'h00);
        check({tag, " seg_lo"}, {1'b0, seg2}, 8'h7F);
        check({tag, " an_lo"}, {5'b0, an2}, 8'h07);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (frame_tick === 1'b1) break;
            n++;
        end
        checks++;
        if (n < 40) passes++;
        else $display("FAIL wait_tick: got no frame_tick expected one within 40 cycles");
    endtask

    task automatic set_digits(input vec_t v);
        ones = v.o; tens = v.t; hundreds = v.h;
    endtask

    initial begin
        vec_t zero_v;
        zero_v    = '{4'd0, 4'd0, 4'd0, 7'h3F, 7'h3F, 7'h3F, 3'b111, 3'b001};
        vecs[0]   = '{4'd4, 4'd0, 4'd2, 7'h66, 7'h3F, 7'h5B, 3'b111, 3'b111};
        vecs[1]   = '{4'd9, 4'd3, 4'd1, 7'h6F, 7'h4F, 7'h06, 3'b111, 3'b111};
        vecs[2]   = '{4'd5, 4'hB, 4'd0, 7'h6D, 7'h40, 7'h3F, 3'b111, 3'b011};
        vecs[3]   = '{4'd0, 4'd1, 4'd0, 7'h3F, 7'h06, 7'h3F, 3'b111, 3'b011};
        vecs[4]   = '{4'd7, 4'd8, 4'd6, 7'h07, 7'h7F, 7'h7D, 3'b111, 3'b111};
        vecs[5]   = '{4'd5, 4'd0, 4'd0, 7'h6D, 7'h3F, 7'h3F, 3'b111, 3'b001};

        // Reset held for three cycles, then the display reads 000.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("reset");
        end
        rst = 1'b0;
        check_frame(zero_v);

        // Table of values, each loaded at the next frame boundary.
        for (int v = 0; v < 6; v++) begin
            set_digits(vecs[v]);
            wait_tick();
            check_frame(vecs[v]);
        end

        // Change 204 -> 139 during the tens slot: current frame stays 204.
        set_digits(vecs[0]);
        wait_tick();
        for (int k = 0; k < 12; k++) begin
            check_cycle(k, vecs[0].s0, vecs[0].s1, vecs[0].s2, pick_show(vecs[0]));
            if (k == 5) set_digits(vecs[1]);
        end
        check_frame(vecs[1]);

        // Reset in the hundreds slot at cnt=2; no tick, restart with snapshot 0.
        for (int k = 0; k < 10; k++)
            check_cycle(k, vecs[1].s0, vecs[1].s1, vecs[1].s2, pick_show(vecs[1]));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        check_frame(zero_v);
        check_frame(vecs[1]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
